// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 64-bit ALU between two requesters: the execute
// stage (requester 0) and the branch/address unit (requester 1). One
// operation is in flight at a time. In IDLE a grant is chosen and the
// granted requester's operands are steered onto the ALU. On the accept edge
// the ALU result and carry-out are registered into a response that is held
// until the owning requester accepts it.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin between the two requesters
//                  undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (bit i = req i)
//   req_a0/b0/op0         requester 0 operands and ALUop
//   req_a1/b1/op1         requester 1 operands and ALUop
//   resp_valid/resp_ready per-requester response handshake (one-hot valid)
//   resp_result           registered ALU result (shared)
//   resp_carryout         registered ALU carry-out
//   alu_a/b/op/carryin    drive the external ALU
//   alu_result/carryout   combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [3:0]       req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carryout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_carryin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             grant_vld;
    logic             grant_idx;
    logic             accept;
    logic             owner_p1;
    logic [1:0]       vld_p1;
    logic [WIDTH-1:0] result_p1;
    logic             carry_p1;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // ---- stage p0: arbitration and ALU operand steering (combinational) ----
`ifdef ALU_ARB_RR_EN
    // Requester that won the most recent accept; reset to 1 so requester 0
    // has first priority.
    logic last_grant_q;

    always_comb begin
        grant_idx = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_idx = ~last_grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant_idx;
        end
    end
`else
    // Requester 0 wins whenever it is valid.
    always_comb begin
        grant_idx = ~req_valid[0];
    end
`endif

    always_comb begin
        grant_vld = (state_q == IDLE) && (req_valid != 2'b00);
        req_ready = grant_vld ? onehot(grant_idx) : 2'b00;
        accept    = grant_vld;

        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant_vld) begin
            if (grant_idx) begin
                alu_a  = req_a1;
                alu_b  = req_b1;
                alu_op = req_op1;
            end else begin
                alu_a  = req_a0;
                alu_b  = req_b0;
                alu_op = req_op0;
            end
        end
        // Inverting b implies the +1 that turns ~b into -b, so a - b is op 0110.
        alu_carryin = alu_op[2];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP: if (resp_ready[owner_p1]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p1: registered response held until owner accepts ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_p1  <= 1'b0;
            vld_p1    <= 2'b00;
            result_p1 <= '0;
            carry_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_p1  <= grant_idx;
                vld_p1    <= onehot(grant_idx);
                result_p1 <= alu_result;
                carry_p1  <= alu_carryout;
            end else if ((state_q == RESP) && resp_ready[owner_p1]) begin
                vld_p1 <= 2'b00;
            end
        end
    end

    assign resp_valid    = vld_p1;
    assign resp_result   = result_p1;
    assign resp_carryout = carry_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]       req_op0, req_op1;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_carryout;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_op;
    logic             alu_carryin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_op0      (req_op0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .req_op1      (req_op1),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_carryout(resp_carryout),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_carryin  (alu_carryin),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout)
    );

    // Reference ALU: [3] invert a, [2] invert b, [1:0] 00 AND, 01 OR, 1x ADD.
    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH:0]   msum;
    always_comb begin
        ma   = alu_op[3] ? ~alu_a : alu_a;
        mb   = alu_op[2] ? ~alu_b : alu_b;
        msum = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, alu_carryin};
        alu_result   = '0;
        alu_carryout = 1'b0;
        if (alu_op[1]) begin
            alu_result   = msum[WIDTH-1:0];
            alu_carryout = msum[WIDTH];
        end else if (alu_op[0]) begin
            alu_result = ma | mb;
        end else begin
            alu_result = ma & mb;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [1:0] exp_grant [4];

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = '0;
        req_a1 = '0; req_b1 = '0; req_op1 = '0;
        do_reset();

        // Reset state
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_result", resp_result, 0);
        check("rst_carryout", resp_carryout, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_op", alu_op, 0);

        // Single op: 5 + 3 from requester 0
        req_valid = 2'b01; req_a0 = 64'd5; req_b0 = 64'd3; req_op0 = 4'b0010;
        #1;
        check("add_req_ready", req_ready, 2'b01);
        check("add_alu_a", alu_a, 64'd5);
        check("add_alu_carryin", alu_carryin, 0);
        step();
        req_valid = 2'b00;
        check("add_resp_valid", resp_valid, 2'b01);
        check("add_resp_result", resp_result, 64'd8);
        check("add_carryout", resp_carryout, 0);
        check("add_alu_zero_in_resp", alu_a, 0);
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        check("add_resp_done", resp_valid, 2'b00);

        // Subtract 3 - 5 from requester 1
        req_valid = 2'b10; req_a1 = 64'd3; req_b1 = 64'd5; req_op1 = 4'b0110;
        #1;
        check("sub_req_ready", req_ready, 2'b10);
        check("sub_alu_carryin", alu_carryin, 1);
        check("sub_alu_b", alu_b, 64'd5);
        step();
        req_valid = 2'b00;
        check("sub_resp_valid", resp_valid, 2'b10);
        check("sub_resp_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_carryout", resp_carryout, 0);
        resp_ready = 2'b01;   // non-owner: ignored
        step();
        check("sub_nonowner_ignored", resp_valid, 2'b10);
        resp_ready = 2'b10;
        step();
        resp_ready = 2'b00;
        check("sub_resp_done", resp_valid, 2'b00);

        // Backpressure: requester 0 keeps req_valid high through RESP
        req_valid = 2'b01; req_a0 = 64'd100; req_b0 = 64'd1; req_op0 = 4'b0010;
        step();
        req_a0 = 64'd7;   // would change the result if sampled again
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", resp_valid, 2'b01);
            check("bp_resp_result", resp_result, 64'd101);
            check("bp_carryout", resp_carryout, 0);
            check("bp_req_ready", req_ready, 2'b00);
            if (i == 4) resp_ready = 2'b10;   // non-owner pulse
            else resp_ready = 2'b00;
            step();
        end
        check("bp_after_pulse", resp_valid, 2'b01);
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        req_valid  = 2'b00;
        check("bp_resp_done", resp_valid, 2'b00);
        #1;
        check("bp_idle_ready", req_ready, 2'b00);

        // Contention with both requesters held valid
        do_reset();
`ifdef ALU_ARB_RR_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif
        req_a0 = 64'd10; req_b0 = 64'd1; req_op0 = 4'b0010;
        req_a1 = 64'd20; req_b1 = 64'd2; req_op1 = 4'b0010;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_req_ready", req_ready, exp_grant[k]);
            step();
            check("cont_resp_valid", resp_valid, exp_grant[k]);
            check("cont_resp_result", resp_result, (exp_grant[k] == 2'b01) ? 64'd11 : 64'd22);
            resp_ready = exp_grant[k];
            step();
            resp_ready = 2'b00;
        end
        req_valid = 2'b00;

        // Reset mid-response
        do_reset();
        req_valid = 2'b01; req_a0 = 64'd9; req_b0 = 64'd9; req_op0 = 4'b0010;
        step();
        req_valid = 2'b00;
        check("rmr_resp_valid", resp_valid, 2'b01);
        check("rmr_resp_result", resp_result, 64'd18);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmr_valid_cleared", resp_valid, 2'b00);
        check("rmr_result_cleared", resp_result, 0);
        check("rmr_idle_ready", req_ready, 2'b00);
        req_valid = 2'b11;
        #1;
        check("rmr_grant0", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("rmr_resp_owner", resp_valid, 2'b01);
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;

        // Logic ops on requester 0
        req_a0 = 64'hF0F0_F0F0_F0F0_F0F0;
        req_b0 = 64'hFF00_FF00_FF00_FF00;
        req_op0 = 4'b0000;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("and_result", resp_result, 64'hF000_F000_F000_F000);
        check("and_carryout", resp_carryout, 0);
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        req_op0 = 4'b0001;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("or_result", resp_result, 64'hFFF0_FFF0_FFF0_FFF0);
        check("or_resp_valid", resp_valid, 2'b01);
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        check("or_resp_done", resp_valid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog: guarantees termination.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the 64-bit ALU between the execute stage (requester 0) and the branch/address unit (requester 1). It accepts one operation at a time over a valid/ready handshake, drives the ALU operand, op and carry-in lines, and registers the ALU result and carry-out into a response held until the owning requester accepts it. It sits between the requesters and the combinational ALU; the ALU itself is instantiated outside this block.

## Interface
- WIDTH, 64, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req_a0, req_b0  in  WIDTH each  requester 0 operands.
- req_op0  in  4  requester 0 ALUop: [3] invert a, [2] invert b, [1:0] 00 AND, 01 OR, 1x ADD.
- req_a1, req_b1, req_op1  in  WIDTH/WIDTH/4  requester 1 equivalents.
- resp_valid  out  2  response valid, one-hot toward the owning requester.
- resp_ready  in  2  per-requester response accept.
- resp_result  out  WIDTH  registered ALU result (shared by both requesters).
- resp_carryout  out  1  registered ALU carry-out.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_op  out  4  ALUop to the ALU.
- alu_carryin  out  1  carry-in to the ALU.
- alu_result  in  WIDTH  ALU result (combinational).
- alu_carryout  in  1  ALU carry-out (combinational).

## Operation
- FSM states: IDLE, RESP. Reset state is IDLE.
- IDLE: the block computes a grant from req_valid (see Configuration) and sets req_ready only for the granted bit. Both req_ready bits are 0 when req_valid == 0.
- In IDLE, alu_a, alu_b and alu_op are a mux of the granted requester's inputs. In RESP, or with no grant, they are all zeros.
- alu_carryin = alu_op[2], so that "invert b, ADD" (0110) forms a - b.
- On the edge where req_valid[g] & req_ready[g]:
  - capture alu_result into resp_result and alu_carryout into resp_carryout;
  - record owner = g, set resp_valid = one-hot(g), go to RESP.
- RESP: outputs hold stable. On resp_ready[owner], clear resp_valid and return to IDLE. resp_ready on the non-owner bit is ignored.
- resp_result and resp_carryout keep their last values after handshake. Only resp_valid indicates validity.
- A requester may hold req_valid through RESP. It is re-arbitrated on return to IDLE.
- Request fields must be stable while req_valid is high. The block samples them only on the accept edge.

## Timing
- Reset values: req_ready = 00, resp_valid = 00, resp_result = 0, resp_carryout = 0, alu_* = 0, owner = 0, last_grant = 1.
- req_ready is combinational from state and req_valid. The ALU path is combinational inside the accept cycle.
- Latency: accept at edge N; resp_valid is high in the cycle after edge N.
- Minimum spacing is 2 cycles per operation (accept, then response handshake). The next accept can happen at the earliest one cycle after the resp handshake edge.
- Simultaneous req_valid = 11 in IDLE: exactly one grant, the other requester waits.
- Reset asserted in any state, including RESP with an un-accepted response: the response is discarded and all registers return to their reset values on that edge.
- No combinational path from resp_ready to req_ready.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration.
  - Grant goes to the requester other than last_grant when both are valid; otherwise to the sole valid requester.
  - last_grant updates on every accept. Reset value 1 gives requester 0 first priority.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins. last_grant is not implemented.

## Test plan
- Single op: reset, then req_valid = 01, a0 = 5, b0 = 3, op0 = 0010. Required: req_ready = 01 in that cycle; next cycle resp_valid = 01, resp_result = 8, carryout = 0. After resp_ready = 01, resp_valid = 00.
- Subtract and carry: requester 1, a1 = 3, b1 = 5, op1 = 0110. Required: alu_carryin = 1; resp_result = 0xFFFF_FFFF_FFFF_FFFE, resp_valid = 10.
- Contention: req_valid held at 11 with ALU_ARB_RR_EN. Required: grants go 0, 1, 0, 1 on successive accepts. Without the macro, all grants go to 0.
- Backpressure: hold resp_ready = 00 for 10 cycles in RESP. Required: resp_valid, resp_result and resp_carryout stay constant, req_ready = 00, and no new accept occurs. Pulse resp_ready on the non-owner bit; required: no effect.
- Reset mid-response: in RESP with resp_valid = 01, assert reset for one cycle. Required: resp_valid = 00, resp_result = 0 and IDLE on the next cycle. Then with req_valid = 11 under RR, requester 0 is granted.
- Logic ops: op 0000 and op 0001 with a = 0xF0F0…, b = 0xFF00… Required: results 0xF000… (AND) and 0xFFF0… (OR).
